// File: rtl/stack_alu_ext.sv
// Stack-based signed ALU with handshake input, multi-cycle shift-add multiply.
// Optional saturation of ADD/SUB/MUL overflow results: define STACK_ALU_SAT_EN.
module stack_alu_ext #(
   parameter int unsigned N     = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [2:0]                opcode,
   input  logic signed [N-1:0]       in_data,
   output logic                      out_valid,
   output logic signed [N-1:0]       out_data,
   output logic                      ovf,
   output logic                      err,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned PW = 2 * N;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_DUP  = 3'b001;
   localparam logic [2:0] OP_SWAP = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_RUN  = 2'd1,
      S_MUL_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [N-1:0]    r_mem [DEPTH];
   logic [LW-1:0]   r_level;
   logic            r_out_valid;
   logic [N-1:0]    r_out_data;
   logic            r_ovf;
   logic            r_err;

   logic [PW-1:0]   r_acc;
   logic [PW-1:0]   r_mcand;
   logic [N-1:0]    r_mplier;
   logic            r_neg;
   logic [CW-1:0]   r_cnt;

   logic [AW-1:0]   w_top_idx;
   logic [AW-1:0]   w_sec_idx;
   logic [AW-1:0]   w_push_idx;
   logic [N-1:0]    w_top;
   logic [N-1:0]    w_sec;
   logic            w_has1;
   logic            w_has2;
   logic            w_full;
   logic            w_accept;
   logic            w_mul_start;

   logic [N:0]      w_sum;
   logic            w_sum_ovf;
   logic [N-1:0]    w_sum_res;

   logic [N-1:0]    w_abs_top;
   logic [N-1:0]    w_abs_sec;
   logic [PW-1:0]   w_prod;
   logic [N:0]      w_prod_hi;
   logic            w_mul_ovf;
   logic [N-1:0]    w_mul_res;

   logic            w_vld_nxt;
   logic [N-1:0]    w_data_nxt;
   logic            w_ovf_nxt;
   logic            w_err_nxt;
   logic [LW-1:0]   w_level_nxt;
   logic            w_we0;
   logic [AW-1:0]   w_wa0;
   logic [N-1:0]    w_wd0;
   logic            w_we1;
   logic [AW-1:0]   w_wa1;
   logic [N-1:0]    w_wd1;

   // Stack addressing: entry level-1 is the top, level-2 the second.
   assign w_top_idx  = AW'(r_level - LW'(1));
   assign w_sec_idx  = AW'(r_level - LW'(2));
   assign w_push_idx = AW'(r_level);
   assign w_top      = r_mem[w_top_idx];
   assign w_sec      = r_mem[w_sec_idx];
   assign w_has1     = (r_level != '0);
   assign w_has2     = (r_level >= LW'(2));
   assign w_full     = (r_level == LW'(DEPTH));

   assign w_accept    = in_valid && (r_state == S_IDLE);
   assign w_mul_start = w_accept && (opcode == OP_MUL) && w_has2;

   // ADD/SUB evaluated one bit wider to expose signed overflow.
   assign w_sum = (opcode == OP_ADD) ? ({w_sec[N-1], w_sec} + {w_top[N-1], w_top})
                                     : ({w_sec[N-1], w_sec} - {w_top[N-1], w_top});
   assign w_sum_ovf = w_sum[N] ^ w_sum[N-1];

   // Multiply runs on magnitudes; sign restored when the product is consumed.
   assign w_abs_top = w_top[N-1] ? (~w_top + N'(1)) : w_top;
   assign w_abs_sec = w_sec[N-1] ? (~w_sec + N'(1)) : w_sec;
   assign w_prod    = r_neg ? (~r_acc + PW'(1)) : r_acc;
   assign w_prod_hi = w_prod[PW-1:N-1];
   assign w_mul_ovf = !((&w_prod_hi) || !(|w_prod_hi));

`ifdef STACK_ALU_SAT_EN
   assign w_sum_res = w_sum_ovf ? (w_sum[N] ? SAT_MIN : SAT_MAX) : w_sum[N-1:0];
   assign w_mul_res = w_mul_ovf ? (w_prod[PW-1] ? SAT_MIN : SAT_MAX) : w_prod[N-1:0];
`else
   assign w_sum_res = w_sum[N-1:0];
   assign w_mul_res = w_prod[N-1:0];
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_mul_start) w_state_nxt = S_MUL_RUN;
         S_MUL_RUN:  if (r_cnt == CW'(N - 1)) w_state_nxt = S_MUL_DONE;
         S_MUL_DONE: w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Output / datapath decode; errors leave the stack untouched.
   always_comb begin
      in_ready    = (r_state == S_IDLE);
      w_vld_nxt   = 1'b0;
      w_data_nxt  = r_out_data;
      w_ovf_nxt   = r_ovf;
      w_err_nxt   = r_err;
      w_level_nxt = r_level;
      w_we0       = 1'b0;
      w_wa0       = w_top_idx;
      w_wd0       = w_top;
      w_we1       = 1'b0;
      w_wa1       = w_sec_idx;
      w_wd1       = w_sec;
      if (r_state == S_MUL_DONE) begin
         w_vld_nxt   = 1'b1;
         w_data_nxt  = w_mul_res;
         w_ovf_nxt   = w_mul_ovf;
         w_err_nxt   = 1'b0;
         w_we0       = 1'b1;
         w_wa0       = w_sec_idx;
         w_wd0       = w_mul_res;
         w_level_nxt = r_level - LW'(1);
      end else if (w_accept && !w_mul_start) begin
         w_vld_nxt  = 1'b1;
         w_data_nxt = '0;
         w_ovf_nxt  = 1'b0;
         w_err_nxt  = 1'b0;
         case (opcode)
            OP_NOP: ;
            OP_DUP: begin
               if (!w_has1 || w_full) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_data_nxt  = w_top;
                  w_we0       = 1'b1;
                  w_wa0       = w_push_idx;
                  w_wd0       = w_top;
                  w_level_nxt = r_level + LW'(1);
               end
            end
            OP_SWAP: begin
               if (!w_has2) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_data_nxt = w_sec;
                  w_we0      = 1'b1;
                  w_wa0      = w_top_idx;
                  w_wd0      = w_sec;
                  w_we1      = 1'b1;
                  w_wa1      = w_sec_idx;
                  w_wd1      = w_top;
               end
            end
            OP_SUB, OP_ADD: begin
               if (!w_has2) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_data_nxt  = w_sum_res;
                  w_ovf_nxt   = w_sum_ovf;
                  w_we0       = 1'b1;
                  w_wa0       = w_sec_idx;
                  w_wd0       = w_sum_res;
                  w_level_nxt = r_level - LW'(1);
               end
            end
            OP_MUL: w_err_nxt = 1'b1;
            OP_PUSH: begin
               if (w_full) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_data_nxt  = in_data;
                  w_we0       = 1'b1;
                  w_wa0       = w_push_idx;
                  w_wd0       = in_data;
                  w_level_nxt = r_level + LW'(1);
               end
            end
            OP_POP: begin
               if (!w_has1) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_data_nxt  = w_top;
                  w_level_nxt = r_level - LW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Result and level registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_ovf       <= 1'b0;
         r_err       <= 1'b0;
         r_level     <= '0;
      end else begin
         r_out_valid <= w_vld_nxt;
         r_out_data  <= w_data_nxt;
         r_ovf       <= w_ovf_nxt;
         r_err       <= w_err_nxt;
         r_level     <= w_level_nxt;
      end
   end

   // Shift-add multiplier: one multiplier bit per cycle in MUL_RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
      end else if (w_mul_start) begin
         r_acc    <= '0;
         r_mcand  <= {{N{1'b0}}, w_abs_sec};
         r_mplier <= w_abs_top;
         r_neg    <= w_top[N-1] ^ w_sec[N-1];
         r_cnt    <= '0;
      end else if (r_state == S_MUL_RUN) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + CW'(1);
      end
   end

   // Stack storage, not reset
   always_ff @(posedge clk) begin
      if (w_we0) r_mem[w_wa0] <= w_wd0;
      if (w_we1) r_mem[w_wa1] <= w_wd1;
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign ovf       = r_ovf;
   assign err       = r_err;
   assign level     = r_level;

endmodule

// File: tb/tb_stack_alu_ext.sv
// Scoreboard bench for stack_alu_ext at N=8, DEPTH=4; honours STACK_ALU_SAT_EN.
module tb_stack_alu_ext;

   localparam int unsigned N     = 8;
   localparam int unsigned DEPTH = 4;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_DUP  = 3'b001;
   localparam logic [2:0] OP_SWAP = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;
   localparam logic [2:0] OP_PUSH = 3'b110;
   localparam logic [2:0] OP_POP  = 3'b111;

`ifdef STACK_ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       ovf;
      logic       err;
      logic [2:0] lvl;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        opcode;
   logic signed [7:0] in_data;
   logic              out_valid;
   logic signed [7:0] out_data;
   logic              ovf;
   logic              err;
   logic [2:0]        level;

   int   n_checks = 0;
   int   n_fails  = 0;
   exp_t q_exp[$];
   exp_t m_e;

   stack_alu_ext #(.N(N), .DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .ovf       (ovf),
      .err       (err),
      .level     (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int d, input bit o, input bit e, input int l);
      exp_t r;
      r.data = 8'(d);
      r.ovf  = o;
      r.err  = e;
      r.lvl  = 3'(l);
      return r;
   endfunction

   // Scoreboard: every out_valid pulse pops and checks the oldest expectation
   always @(negedge clk) begin
      if (out_valid) begin
         if (q_exp.size() == 0) begin
            check_eq("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            m_e = q_exp.pop_front();
            check_eq("out_data", {24'd0, out_data}, {24'd0, m_e.data});
            check_eq("ovf",      32'(ovf),          32'(m_e.ovf));
            check_eq("err",      32'(err),          32'(m_e.err));
            check_eq("level",    32'(level),        32'(m_e.lvl));
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic do_cmd(input logic [2:0] op, input int d, input exp_t x);
      wait_ready();
      in_valid = 1'b1;
      opcode   = op;
      in_data  = 8'(d);
      q_exp.push_back(x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("one_cycle_valid", 32'(out_valid), 32'd1);
      check_eq("ready_stays", 32'(in_ready), 32'd1);
   endtask

   // MUL with junk PUSH held on the inputs while busy; it must be ignored
   task automatic do_mul(input exp_t x);
      int lat  = 0;
      bit seen = 1'b0;
      wait_ready();
      in_valid = 1'b1;
      opcode   = OP_MUL;
      in_data  = 8'($urandom);
      q_exp.push_back(x);
      @(posedge clk);
      #1;
      check_eq("mul_busy_k1", 32'(in_ready), 32'd0);
      opcode = OP_PUSH;
      while (!seen && lat < int'(N) + 4) begin
         @(posedge clk);
         #1;
         lat++;
         if (out_valid) seen = 1'b1;
         else if (lat < int'(N)) check_eq("mul_busy", 32'(in_ready), 32'd0);
         if (lat == int'(N)) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      check_eq("mul_latency", 32'(lat), 32'(N + 1));
      check_eq("mul_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      opcode   = OP_NOP;
      in_data  = '0;
      #2;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data",  {24'd0, out_data}, 32'd0);
      check_eq("rst_ovf",       32'(ovf), 32'd0);
      check_eq("rst_err",       32'(err), 32'd0);
      check_eq("rst_level",     32'(level), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);

      // ADD overflow, then SUB negative overflow
      do_cmd(OP_PUSH, 100, mk(100, 0, 0, 1));
      do_cmd(OP_PUSH, 50,  mk(50, 0, 0, 2));
      do_cmd(OP_ADD,  0,   mk(SAT ? 127 : -106, 1, 0, 1));
      do_cmd(OP_POP,  0,   mk(SAT ? 127 : -106, 0, 0, 0));
      do_cmd(OP_PUSH, -100, mk(-100, 0, 0, 1));
      do_cmd(OP_PUSH, 100,  mk(100, 0, 0, 2));
      do_cmd(OP_SUB,  0,    mk(SAT ? -128 : 56, 1, 0, 1));
      do_cmd(OP_POP,  0,    mk(SAT ? -128 : 56, 0, 0, 0));
      do_cmd(OP_PUSH, 5,  mk(5, 0, 0, 1));
      do_cmd(OP_PUSH, -3, mk(-3, 0, 0, 2));
      do_cmd(OP_ADD,  0,  mk(2, 0, 0, 1));
      do_cmd(OP_PUSH, -3, mk(-3, 0, 0, 2));
      do_cmd(OP_SUB,  0,  mk(5, 0, 0, 1));
      do_cmd(OP_POP,  0,  mk(5, 0, 0, 0));

      // Multiply: in-range, negative overflow, -128 * -1
      do_cmd(OP_PUSH, -7, mk(-7, 0, 0, 1));
      do_cmd(OP_PUSH, 9,  mk(9, 0, 0, 2));
      do_mul(mk(-63, 0, 0, 1));
      repeat (3) @(posedge clk);
      #1;
      check_eq("hold_data", {24'd0, out_data}, 32'h0000_00C1);
      do_cmd(OP_POP,  0,   mk(-63, 0, 0, 0));
      do_cmd(OP_PUSH, 20,  mk(20, 0, 0, 1));
      do_cmd(OP_PUSH, -10, mk(-10, 0, 0, 2));
      do_mul(mk(SAT ? -128 : 56, 1, 0, 1));
      do_cmd(OP_POP,  0,   mk(SAT ? -128 : 56, 0, 0, 0));
      do_cmd(OP_PUSH, -128, mk(-128, 0, 0, 1));
      do_cmd(OP_PUSH, -1,   mk(-1, 0, 0, 2));
      do_mul(mk(SAT ? 127 : -128, 1, 0, 1));
      do_cmd(OP_POP,  0,    mk(SAT ? 127 : -128, 0, 0, 0));

      // Underflow cases, including single-cycle erroring MUL
      do_cmd(OP_PUSH, 3, mk(3, 0, 0, 1));
      do_cmd(OP_SUB,  0, mk(0, 0, 1, 1));
      do_cmd(OP_MUL,  0, mk(0, 0, 1, 1));
      do_cmd(OP_SWAP, 0, mk(0, 0, 1, 1));
      do_cmd(OP_POP,  0, mk(3, 0, 0, 0));
      do_cmd(OP_POP,  0, mk(0, 0, 1, 0));
      do_cmd(OP_DUP,  0, mk(0, 0, 1, 0));
      do_cmd(OP_NOP,  0, mk(0, 0, 0, 0));

      // Full stack
      for (int i = 1; i <= 4; i++) do_cmd(OP_PUSH, i, mk(i, 0, 0, i));
      do_cmd(OP_PUSH, 5, mk(0, 0, 1, 4));
      do_cmd(OP_DUP,  0, mk(0, 0, 1, 4));
      do_cmd(OP_POP,  0, mk(4, 0, 0, 3));
      do_cmd(OP_DUP,  0, mk(3, 0, 0, 4));
      do_cmd(OP_POP,  0, mk(3, 0, 0, 3));
      do_cmd(OP_POP,  0, mk(3, 0, 0, 2));
      do_cmd(OP_POP,  0, mk(2, 0, 0, 1));
      do_cmd(OP_POP,  0, mk(1, 0, 0, 0));

      // SWAP
      do_cmd(OP_PUSH, 1, mk(1, 0, 0, 1));
      do_cmd(OP_PUSH, 2, mk(2, 0, 0, 2));
      do_cmd(OP_SWAP, 0, mk(1, 0, 0, 2));
      do_cmd(OP_POP,  0, mk(1, 0, 0, 1));
      do_cmd(OP_POP,  0, mk(2, 0, 0, 0));
      do_cmd(OP_POP,  0, mk(0, 0, 1, 0));

      // Reset in the middle of a multiply
      do_cmd(OP_PUSH, 2, mk(2, 0, 0, 1));
      do_cmd(OP_PUSH, 3, mk(3, 0, 0, 2));
      wait_ready();
      in_valid = 1'b1;
      opcode   = OP_MUL;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_level",     32'(level), 32'd0);
      check_eq("abort_out_valid", 32'(out_valid), 32'd0);
      check_eq("abort_out_data",  {24'd0, out_data}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_eq("abort_ready", 32'(in_ready), 32'd1);
      pulses = 0;
      repeat (N + 4) begin
         @(posedge clk);
         #1;
         if (out_valid) pulses++;
      end
      check_eq("abort_no_pulse", 32'(pulses), 32'd0);
      do_cmd(OP_PUSH, 7, mk(7, 0, 0, 1));
      do_cmd(OP_POP,  0, mk(7, 0, 0, 0));

      repeat (3) @(posedge clk);
      #1;
      check_eq("queue_empty", 32'(q_exp.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/stack_alu_ext.md
STACK_ALU_EXT -- requirements
Module: stack_alu_ext

Interface
REQ-001 Parameter N, default 16, SHALL set the signed two's-complement data width; legal range 4..32.
REQ-002 Parameter DEPTH, default 16, SHALL set the stack entry count; legal values are powers of two from 2 to 1024.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit, SHALL indicate that a command is presented.
REQ-006 Port in_ready, output, 1 bit, SHALL indicate that the block can accept a command.
REQ-007 Port opcode, input, 3 bits, SHALL carry the command.
REQ-008 Port in_data, input, N bits signed, SHALL carry the PUSH operand.
REQ-009 Port out_valid, output, 1 bit, SHALL be a one-cycle pulse marking a completed command.
REQ-010 Port out_data, output, N bits signed, SHALL carry the command result.
REQ-011 Port ovf, output, 1 bit, SHALL flag arithmetic overflow, qualified by out_valid.
REQ-012 Port err, output, 1 bit, SHALL flag stack underflow or full, qualified by out_valid.
REQ-013 Port level, output, clog2(DEPTH)+1 bits, SHALL report the current entry count.

Function
REQ-014 A command SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the edge of acceptance is edge k.
REQ-015 Opcodes SHALL be decoded as follows.
- 000 NOP
- 001 DUP
- 010 SWAP
- 011 SUB (second minus top)
- 100 ADD
- 101 MUL
- 110 PUSH
- 111 POP
REQ-016 ADD, SUB and MUL SHALL pop two operands and push one result, so level decreases by 1.
REQ-017 For all commands except MUL, out_valid, out_data, ovf and err SHALL be registered at edge k, with zero-cycle stall; in_ready SHALL stay 1.
REQ-018 The FSM SHALL have three states.
- IDLE: in_ready=1.
- MUL_RUN: in_ready=0.
- MUL_DONE: in_ready=0.
REQ-019 MUL state transitions SHALL be as follows.
- Acceptance at edge k: IDLE to MUL_RUN.
- After N shift-add iterations: MUL_RUN to MUL_DONE.
- At edge k+N+1: MUL_DONE to IDLE, with out_valid asserted and in_ready returning to 1.
REQ-020 MUL SHALL form the full 2N-bit signed product; out_data SHALL be its low N bits; ovf=1 iff the product lies outside the signed N-bit range.
REQ-021 For ADD and SUB, ovf SHALL be 1 iff the true N+1-bit result lies outside the signed N-bit range; out_data SHALL be the wrapped low N bits.
REQ-022 PUSH SHALL write in_data and set out_data=in_data.
REQ-023 POP SHALL set out_data to the top entry and remove it.
REQ-024 DUP SHALL set out_data to the top entry and push a copy of it.
REQ-025 SWAP SHALL exchange the top two entries and set out_data to the new top.
REQ-026 Insufficient operands SHALL leave the stack unchanged and give err=1, out_data=0, ovf=0. Required operand counts:
- ADD, SUB, MUL, SWAP: at least 2.
- POP, DUP: at least 1.
REQ-027 PUSH or DUP with level==DEPTH SHALL leave the stack unchanged and give err=1, out_data=0.
REQ-028 NOP SHALL pulse out_valid with out_data=0, ovf=0, err=0.
REQ-029 An erroring MUL SHALL complete in one cycle like the other opcodes and SHALL NOT enter MUL_RUN.
REQ-030 out_data, ovf and err SHALL hold their values between out_valid pulses.
REQ-031 No command SHALL be accepted while in_ready=0; in_valid, opcode and in_data SHALL be ignored in that period.

Reset
REQ-032 rst_n low SHALL immediately force the following, regardless of the clock.
- State = IDLE; level = 0.
- out_valid = 0, out_data = 0, ovf = 0, err = 0.
- in_ready = 1 after release.
REQ-033 Reset during MUL_RUN or MUL_DONE SHALL abort the multiply with no out_valid pulse.
REQ-034 Stack storage contents need not be reset.

Configuration
REQ-035 When macro STACK_ALU_SAT_EN is defined, ADD, SUB and MUL results with ovf=1 SHALL saturate: +2^(N-1)-1 for positive true results, -2^(N-1) for negative; ovf is still reported.
REQ-036 When STACK_ALU_SAT_EN is undefined, results SHALL wrap per REQ-020 and REQ-021.

Verification (N=8, DEPTH=4)
REQ-037 Scenario 1: PUSH 100, PUSH 50, ADD -> out_data=-106 (wrap), ovf=1, level=1; with STACK_ALU_SAT_EN -> out_data=127.
REQ-038 Scenario 2: PUSH -7, PUSH 9, MUL accepted at edge k -> in_ready=0 for edges k+1..k+N, out_valid at edge k+9, out_data=-63, ovf=0, level=1.
REQ-039 Scenario 3: PUSH 3, SUB -> err=1, level=1, stack top still 3 (confirmed by POP -> out_data=3).
REQ-040 Scenario 4: four PUSHes then PUSH 5 -> err=1, level=4; then DUP -> err=1.
REQ-041 Scenario 5: PUSH 1, PUSH 2, SWAP -> out_data=1; POP -> out_data=1; POP -> out_data=2; POP -> err=1.
REQ-042 Scenario 6: assert rst_n low mid-MUL_RUN -> no out_valid pulse, level=0, in_ready=1 after release.
